// File: rtl/mem_write_checker.sv
// Data-memory write-bus monitor: checks an ordered list of expected stores,
// skips a scratch address window, and reports pass / fail / timeout.
module mem_write_checker #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_CHECKS = 4,
    parameter int                TIMEOUT    = 50,
    parameter logic [ADDR_W-1:0] IGN_LO     = ADDR_W'(80),
    parameter logic [ADDR_W-1:0] IGN_HI     = ADDR_W'(80),
    parameter int                CNT_W      = 16,
    localparam int               MI_W       = $clog2(NUM_CHECKS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_enable,
    input  logic [ADDR_W-1:0]            address_bus,
    input  logic [DATA_W-1:0]            data_bus,
    input  logic [NUM_CHECKS*ADDR_W-1:0] exp_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [MI_W-1:0]              match_idx,
    output logic [CNT_W-1:0]             ign_count,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [DATA_W-1:0]            fail_data
);

    // state   | meaning
    // ST_RUN  | checking stores, counting cycles
    // ST_PASS | every expected store matched in order (sticky)
    // ST_FAIL | non-ignored store did not match the current entry (sticky)
    // ST_TMO  | TIMEOUT cycles spent in RUN without a verdict (sticky)
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_TMO  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [MI_W-1:0]     r_match_idx;
    logic [CNT_W-1:0]    r_ign_count;
    logic [CNT_W-1:0]    r_cycle_count;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_data;

    logic [ADDR_W-1:0]   w_exp_a;
    logic [DATA_W-1:0]   w_exp_d;
    logic                w_in_win;
    logic                w_eq;
    logic                w_is_ign;
    logic                w_is_match;
    logic                w_is_miss;
    logic [MI_W-1:0]     w_idx_inc;
    logic                w_last;
    logic [CNT_W-1:0]    w_cyc_inc;
    logic [CNT_W-1:0]    w_ign_inc;
    logic                w_tmo;

    // Select the entry currently awaited; match_idx never exceeds the
    // table while in RUN, so the out-of-range case needs no handling.
    always_comb begin
        w_exp_a = '0;
        w_exp_d = '0;
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if (r_match_idx == MI_W'(k)) begin
                w_exp_a = exp_addr[k*ADDR_W +: ADDR_W];
                w_exp_d = exp_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // An inverted window (IGN_LO > IGN_HI) turns ignoring off entirely.
    assign w_in_win   = (IGN_LO <= IGN_HI) &&
                        (address_bus >= IGN_LO) && (address_bus <= IGN_HI);
    assign w_eq       = (address_bus == w_exp_a) && (data_bus == w_exp_d);

    assign w_is_ign   = write_enable &&  w_in_win;
    assign w_is_match = write_enable && !w_in_win &&  w_eq;
    assign w_is_miss  = write_enable && !w_in_win && !w_eq;

    assign w_idx_inc  = r_match_idx + 1'b1;
    assign w_last     = (w_idx_inc == MI_W'(NUM_CHECKS));

    assign w_cyc_inc  = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
    assign w_ign_inc  = (&r_ign_count)   ? r_ign_count   : r_ign_count + 1'b1;
    assign w_tmo      = (w_cyc_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A store on the timeout edge is classified first, so PASS/FAIL win.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_is_match && w_last) begin
                    w_state_nxt = ST_PASS;
                end else if (w_is_miss) begin
                    w_state_nxt = ST_FAIL;
                end else if (w_tmo) begin
                    w_state_nxt = ST_TMO;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_idx   <= '0;
            r_ign_count   <= '0;
            r_cycle_count <= '0;
            r_fail_addr   <= '0;
            r_fail_data   <= '0;
        end else if (r_state == ST_RUN) begin
            r_cycle_count <= w_cyc_inc;
            if (w_is_ign) begin
                r_ign_count <= w_ign_inc;
            end
            if (w_is_match) begin
                r_match_idx <= w_idx_inc;
            end
            if (w_is_miss) begin
                r_fail_addr <= address_bus;
                r_fail_data <= data_bus;
            end
        end
    end

    always_comb begin
        pass    = 1'b0;
        fail    = 1'b0;
        timeout = 1'b0;
        case (r_state)
            ST_PASS: pass    = 1'b1;
            ST_FAIL: fail    = 1'b1;
            ST_TMO:  timeout = 1'b1;
            default: ;
        endcase
        done = pass | fail | timeout;
    end

    assign match_idx   = r_match_idx;
    assign ign_count   = r_ign_count;
    assign cycle_count = r_cycle_count;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: three configurations share one bus;
// expected status snapshots are queued and checked by a separate monitor.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        rst1 = 1'b1, rst3 = 1'b1, rstw = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0, data = '0;

    logic [31:0] ea1 = 32'd84, ed1 = 32'd7;
    logic [95:0] ea3 = {32'd92, 32'd88, 32'd84};
    logic [95:0] ed3 = {32'd1, 32'd9, 32'd7};

    logic        dn1, ps1, fl1, to1, dn3, ps3, fl3, to3, dnw, psw, flw, tow;
    logic [0:0]  mi1, miw;
    logic [1:0]  mi3;
    logic [15:0] ic1, cc1, ic3, cc3, icw, ccw;
    logic [31:0] fa1, fd1, fa3, fd3, faw, fdw;

    mem_write_checker #(.NUM_CHECKS(1)) u1 (
        .clk(clk), .rst(rst1), .write_enable(we), .address_bus(addr), .data_bus(data),
        .exp_addr(ea1), .exp_data(ed1), .done(dn1), .pass(ps1), .fail(fl1), .timeout(to1),
        .match_idx(mi1), .ign_count(ic1), .cycle_count(cc1), .fail_addr(fa1), .fail_data(fd1));

    mem_write_checker #(.NUM_CHECKS(3)) u3 (
        .clk(clk), .rst(rst3), .write_enable(we), .address_bus(addr), .data_bus(data),
        .exp_addr(ea3), .exp_data(ed3), .done(dn3), .pass(ps3), .fail(fl3), .timeout(to3),
        .match_idx(mi3), .ign_count(ic3), .cycle_count(cc3), .fail_addr(fa3), .fail_data(fd3));

    mem_write_checker #(.NUM_CHECKS(1), .IGN_LO(32'd96), .IGN_HI(32'd127)) uw (
        .clk(clk), .rst(rstw), .write_enable(we), .address_bus(addr), .data_bus(data),
        .exp_addr(ea1), .exp_data(ed1), .done(dnw), .pass(psw), .fail(flw), .timeout(tow),
        .match_idx(miw), .ign_count(icw), .cycle_count(ccw), .fail_addr(faw), .fail_data(fdw));

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    cyc;
        int    dut;
        int    p, f, t, midx, ign, cc, fa, fd;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s.%s got=%0d want=%0d", tag, nm, act, want);
        end
    endtask

    // Monitor: pops every snapshot due at this cycle and compares it.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
            exp_t e;
            int d, p, f, t, mi, ic, cc, fa, fd;
            e = q.pop_front();
            case (e.dut)
                0: begin d = dn1; p = ps1; f = fl1; t = to1; mi = int'(mi1);
                         ic = int'(ic1); cc = int'(cc1); fa = int'(fa1); fd = int'(fd1); end
                1: begin d = dn3; p = ps3; f = fl3; t = to3; mi = int'(mi3);
                         ic = int'(ic3); cc = int'(cc3); fa = int'(fa3); fd = int'(fd3); end
                default: begin d = dnw; p = psw; f = flw; t = tow; mi = int'(miw);
                         ic = int'(icw); cc = int'(ccw); fa = int'(faw); fd = int'(fdw); end
            endcase
            chk(e.tag, "sample_cycle", edge_cnt, e.cyc);
            chk(e.tag, "done", d, (e.p | e.f | e.t));
            chk(e.tag, "pass", p, e.p);
            chk(e.tag, "fail", f, e.f);
            chk(e.tag, "timeout", t, e.t);
            chk(e.tag, "match_idx", mi, e.midx);
            chk(e.tag, "ign_count", ic, e.ign);
            chk(e.tag, "cycle_count", cc, e.cc);
            chk(e.tag, "fail_addr", fa, e.fa);
            chk(e.tag, "fail_data", fd, e.fd);
        end
    end

    task automatic expect_st(input string tag, input int dut, input int p, input int f,
                             input int t, input int midx, input int ign, input int cc,
                             input int fa, input int fd);
        exp_t e;
        e.tag = tag; e.cyc = edge_cnt; e.dut = dut;
        e.p = p; e.f = f; e.t = t; e.midx = midx; e.ign = ign; e.cc = cc; e.fa = fa; e.fd = fd;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; data = d;
        step();
        we = 1'b0; addr = 32'hdead_0000; data = 32'hbeef_0000;
    endtask

    task automatic pulse_rst(input int dut);
        case (dut)
            0: rst1 = 1'b1;
            1: rst3 = 1'b1;
            default: rstw = 1'b1;
        endcase
        step();
        rst1 = 1'b1; rst3 = 1'b1; rstw = 1'b1;
        case (dut)
            0: rst1 = 1'b0;
            1: rst3 = 1'b0;
            default: rstw = 1'b0;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);

        // ignored stores then a match on a single-entry list
        pulse_rst(0);       expect_st("t1_rst",   0, 0,0,0, 0, 0, 0,  0, 0);
        store(80, 3);       expect_st("t1_ign1",  0, 0,0,0, 0, 1, 1,  0, 0);
        store(80, 5);       expect_st("t1_ign2",  0, 0,0,0, 0, 2, 2,  0, 0);
        store(84, 7);       expect_st("t1_pass",  0, 1,0,0, 1, 2, 3,  0, 0);
        store(84, 6);       expect_st("t1_stick", 0, 1,0,0, 1, 2, 3,  0, 0);

        // data mismatch, later good store cannot rescue
        pulse_rst(0);       expect_st("t2_rst",   0, 0,0,0, 0, 0, 0,  0, 0);
        store(84, 6);       expect_st("t2_fail",  0, 0,1,0, 0, 0, 1, 84, 6);
        store(84, 7);       expect_st("t2_stick", 0, 0,1,0, 0, 0, 1, 84, 6);

        // address mismatch, then reset recovers
        pulse_rst(0);       expect_st("t3_rst",   0, 0,0,0, 0, 0, 0,  0, 0);
        store(88, 7);       expect_st("t3_fail",  0, 0,1,0, 0, 0, 1, 88, 7);
        pulse_rst(0);       expect_st("t3_rst2",  0, 0,0,0, 0, 0, 0,  0, 0);
        store(84, 7);       expect_st("t3_pass",  0, 1,0,0, 1, 0, 1,  0, 0);

        // idle timeout on the 50th RUN edge
        pulse_rst(0);       expect_st("t4_rst",   0, 0,0,0, 0, 0, 0,  0, 0);
        idle(49);           expect_st("t4_49",    0, 0,0,0, 0, 0, 49, 0, 0);
        idle(1);            expect_st("t4_tmo",   0, 0,0,1, 0, 0, 50, 0, 0);
        store(84, 7);       expect_st("t4_stick", 0, 0,0,1, 0, 0, 50, 0, 0);

        // three-entry list, final store lands on the timeout edge
        rst1 = 1'b1;
        pulse_rst(1);       expect_st("t5_rst",   1, 0,0,0, 0, 0, 0,  0, 0);
        store(84, 7);       expect_st("t5_m1",    1, 0,0,0, 1, 0, 1,  0, 0);
        store(88, 9);       expect_st("t5_m2",    1, 0,0,0, 2, 0, 2,  0, 0);
        idle(47);           expect_st("t5_wait",  1, 0,0,0, 2, 0, 49, 0, 0);
        store(92, 1);       expect_st("t5_pass",  1, 1,0,0, 3, 0, 50, 0, 0);

        // out-of-order store fails at entry 1
        pulse_rst(1);       expect_st("t5b_rst",  1, 0,0,0, 0, 0, 0,  0, 0);
        store(84, 7);       expect_st("t5b_m1",   1, 0,0,0, 1, 0, 1,  0, 0);
        store(92, 1);       expect_st("t5b_fail", 1, 0,1,0, 1, 0, 2, 92, 1);

        // ignored store on the timeout edge: timeout still taken
        pulse_rst(1);       expect_st("t5c_rst",  1, 0,0,0, 0, 0, 0,  0, 0);
        idle(49);
        store(80, 1);       expect_st("t5c_tmo",  1, 0,0,1, 0, 1, 50, 0, 0);

        // wide ignore window, reset beats a simultaneous matching store
        rst3 = 1'b1;
        pulse_rst(2);       expect_st("t6_rst",   2, 0,0,0, 0, 0, 0,  0, 0);
        store(100, 7);      expect_st("t6_ign",   2, 0,0,0, 0, 1, 1,  0, 0);
        rstw = 1'b1; we = 1'b1; addr = 32'd84; data = 32'd7;
        step();
        we = 1'b0; rstw = 1'b0;
                            expect_st("t6_rstwin",2, 0,0,0, 0, 0, 0,  0, 0);
        store(96, 1);       expect_st("t6_lo",    2, 0,0,0, 0, 1, 1,  0, 0);
        store(127, 2);      expect_st("t6_hi",    2, 0,0,0, 0, 2, 2,  0, 0);
        store(84, 7);       expect_st("t6_pass",  2, 1,0,0, 1, 2, 3,  0, 0);
        pulse_rst(2);       expect_st("t6_rst2",  2, 0,0,0, 0, 0, 0,  0, 0);
        store(95, 7);       expect_st("t6_below", 2, 0,1,0, 0, 0, 1, 95, 7);

        idle(2);
        chk("end", "queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Synthesizable, parametrised monitor for the data-memory write bus of the single-cycle MIPS core. It checks an ordered list of NUM_CHECKS expected (address, data) stores against the bus. Stores inside a configurable scratch address window are ignored. The block flags pass, fail or timeout and records diagnostic data, so top-level benches and FPGA builds read one status word instead of using ad-hoc stop logic.

Parameters:
ADDR_W, 32, address bus width
DATA_W, 32, data bus width
NUM_CHECKS, 4, number of expected stores, checked in order (>=1)
TIMEOUT, 50, cycles in RUN before timeout (>=1)
IGN_LO, 80, lowest ignored address (inclusive)
IGN_HI, 80, highest ignored address (inclusive); IGN_LO>IGN_HI disables ignoring
CNT_W, 16, width of cycle and ignore counters

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
write_enable  in  1  memory write strobe from the core
address_bus  in  ADDR_W  store address
data_bus  in  DATA_W  store data
exp_addr  in  NUM_CHECKS*ADDR_W  expected addresses, entry k at bits [k*ADDR_W +: ADDR_W]; held stable while not rst
exp_data  in  NUM_CHECKS*DATA_W  expected data, same packing
done  out  1  any terminal state reached
pass  out  1  all checks matched
fail  out  1  mismatching non-ignored store seen
timeout  out  1  TIMEOUT cycles elapsed without pass/fail
match_idx  out  $clog2(NUM_CHECKS+1)  number of checks matched so far
ign_count  out  CNT_W  ignored stores seen (saturating)
cycle_count  out  CNT_W  cycles spent in RUN (saturating)
fail_addr  out  ADDR_W  address of the offending store
fail_data  out  DATA_W  data of the offending store

Behaviour:
- Reset: rst high at a rising edge puts the block in RUN, clears all outputs, counters and fail_* to 0. rst takes priority over everything, including mid-run and in terminal states.
- States:
  - RUN: active checking.
  - PASS, FAIL, TIMEOUT: terminal and sticky until rst; bus activity in these states changes nothing.
- In RUN, each edge with write_enable=1 is classified in this priority order:
  1. IGN_LO<=address_bus<=IGN_HI (unsigned): ign_count+1, match_idx unchanged.
  2. address_bus==exp_addr[match_idx] and data_bus==exp_data[match_idx]: match_idx+1. If the new value is NUM_CHECKS, go to PASS.
  3. Otherwise: go to FAIL and capture address_bus/data_bus into fail_addr/fail_data. match_idx holds the index of the failed entry.
- write_enable=0: no classification; X on the buses is ignored.
- cycle_count increments every RUN cycle, including the cycle that leaves RUN.
- When cycle_count would reach TIMEOUT on an edge:
  - A store on that same edge is classified first. PASS or FAIL wins over TIMEOUT.
  - Otherwise go to TIMEOUT.
- Latency: status outputs are registered and valid the edge after the deciding store. done = pass|fail|timeout. At most one of pass/fail/timeout is ever high.
- An expected entry that lies inside the ignore window can never match: the store is ignored. This is legal configuration, not detected.
- ign_count and cycle_count saturate at all-ones.
- No combinational path from inputs to outputs.

Test Plan:
- Defaults; exp_addr entry 0=84, exp_data entry 0=7, NUM_CHECKS=1 override; stores (80,3), (80,5), (84,7) -> pass=1 the edge after (84,7), ign_count=2, match_idx=1, fail=0.
- NUM_CHECKS=1, expect (84,7); store (84,6) -> fail=1, fail_addr=84, fail_data=6, match_idx=0. A later (84,7) leaves the state as FAIL.
- NUM_CHECKS=1; store (88,7) -> fail=1, fail_addr=88. Then rst for 1 cycle -> all outputs 0, state RUN. Then (84,7) -> pass=1.
- No stores for 50 cycles after reset release -> timeout=1 on the 50th RUN edge, cycle_count=50, done=1, pass=fail=0.
- NUM_CHECKS=3, expects (84,7), (88,9), (92,1); final store lands exactly on the 50th cycle -> pass=1, timeout=0, match_idx=3.
- Store (100,7) while expecting (84,7) with IGN_LO=96, IGN_HI=127 -> ignored, ign_count=1. Assert rst in the same cycle as a matching store -> reset wins, match_idx=0.
